// File: rtl/alu_rr_scheduler_if.sv
// Requester-side bundle for alu_rr_scheduler: per-requester request levels and
// packed operands going in, one-hot grant/ack and the captured result coming back.
// slave = scheduler side, master = requester side.
interface alu_rr_scheduler_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]      req;
    logic [16*NREQ-1:0]   req_a;
    logic [16*NREQ-1:0]   req_b;
    logic [NREQ-1:0]      req_cin;
    logic [3*NREQ-1:0]    req_op;
    logic [NREQ-1:0]      grant;
    logic [NREQ-1:0]      ack;
    logic [15:0]          res_w;
    logic                 res_z;
    logic                 res_n;

    modport slave (
        input  req, req_a, req_b, req_cin, req_op,
        output grant, ack, res_w, res_z, res_n
    );

    modport master (
        output req, req_a, req_b, req_cin, req_op,
        input  grant, ack, res_w, res_z, res_n
    );
endinterface

// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler sharing one combinational 16-bit ALU among NREQ requesters.
// The winner's operands are registered onto the ALU, held for ALU_WAIT cycles, then
// the result/flags are captured and a one-cycle ack is returned to the winner.
// Optional macro ALU_RR_STATS_EN builds a saturating completed-operation counter on
// op_count; without it op_count is tied to zero.
module alu_rr_scheduler #(
    parameter int NREQ     = 4,
    parameter int ALU_WAIT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_rr_scheduler_if.slave    rq,
    output logic [15:0]          alu_a,
    output logic [15:0]          alu_b,
    output logic                 alu_cin,
    output logic [2:0]           alu_op,
    input  logic [15:0]          alu_w,
    input  logic                 alu_z,
    input  logic                 alu_n,
    output logic                 busy,
    output logic [15:0]          op_count
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     win_q, win_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [15:0]       alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic              alu_cin_q, alu_cin_d;
    logic [2:0]        alu_op_q, alu_op_d;
    logic [NREQ-1:0]   grant_q, grant_d, ack_q, ack_d;
    logic [15:0]       res_w_q, res_w_d;
    logic              res_z_q, res_z_d, res_n_q, res_n_d;

    logic              found;
    logic [PW-1:0]     pick;
    int                idx;

    // Find the first requester at or above the pointer, wrapping past NREQ-1.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && rq.req[idx]) begin
                found = 1'b1;
                pick  = PW'(idx);
            end
        end
    end

    // Next state: grant/latch in IDLE, count down in EXEC, release in RESP.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        win_d     = win_q;
        cnt_d     = cnt_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_cin_d = alu_cin_q;
        alu_op_d  = alu_op_q;
        grant_d   = grant_q;
        ack_d     = ack_q;
        res_w_d   = res_w_q;
        res_z_d   = res_z_q;
        res_n_d   = res_n_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    win_d     = pick;
                    alu_a_d   = rq.req_a[16*pick +: 16];
                    alu_b_d   = rq.req_b[16*pick +: 16];
                    alu_cin_d = rq.req_cin[pick];
                    alu_op_d  = rq.req_op[3*pick +: 3];
                    grant_d   = {{(NREQ-1){1'b0}}, 1'b1} << pick;
                    cnt_d     = 4'(ALU_WAIT - 1);
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    res_w_d = alu_w;
                    res_z_d = alu_z;
                    res_n_d = alu_n;
                    ack_d   = grant_q;
                    state_d = RESP;
                end
            end
            RESP: begin
                // Pointer moves only on completion, so the next search starts past the winner.
                ack_d   = '0;
                grant_d = '0;
                ptr_d   = (win_q == PW'(NREQ - 1)) ? '0 : win_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset drops any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            win_q     <= '0;
            cnt_q     <= '0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_cin_q <= 1'b0;
            alu_op_q  <= '0;
            grant_q   <= '0;
            ack_q     <= '0;
            res_w_q   <= '0;
            res_z_q   <= 1'b0;
            res_n_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            win_q     <= win_d;
            cnt_q     <= cnt_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_cin_q <= alu_cin_d;
            alu_op_q  <= alu_op_d;
            grant_q   <= grant_d;
            ack_q     <= ack_d;
            res_w_q   <= res_w_d;
            res_z_q   <= res_z_d;
            res_n_q   <= res_n_d;
        end
    end

    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign alu_cin  = alu_cin_q;
    assign alu_op   = alu_op_q;
    assign rq.grant = grant_q;
    assign rq.ack   = ack_q;
    assign rq.res_w = res_w_q;
    assign rq.res_z = res_z_q;
    assign rq.res_n = res_n_q;
    assign busy     = (state_q != IDLE);

`ifdef ALU_RR_STATS_EN
    logic [15:0] op_cnt_q, op_cnt_d;

    // Count completions (EXEC->RESP), saturating at all-ones.
    always_comb begin
        op_cnt_d = op_cnt_q;
        if (state_q == EXEC && cnt_q == 4'd0 && op_cnt_q != 16'hFFFF)
            op_cnt_d = op_cnt_q + 16'd1;
    end

    // Completion counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) op_cnt_q <= '0;
        else        op_cnt_q <= op_cnt_d;
    end

    assign op_count = op_cnt_q;
`else
    assign op_count = 16'h0000;
`endif
endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Bench for alu_rr_scheduler: directed scenarios plus randomized requester agents.
// Expected results are queued per issued request; a monitor checks grant order,
// latency, ack shape and captured results whenever the DUT acknowledges.
module tb_alu_rr_scheduler;
    localparam int NREQ = 4;
    localparam int WAIT = 3;
`ifdef ALU_RR_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_rr_scheduler_if #(.NREQ(NREQ)) rq ();

    logic [15:0] alu_a, alu_b, alu_w, op_count;
    logic        alu_cin, alu_z, alu_n, busy;
    logic [2:0]  alu_op;

    alu_rr_scheduler #(.NREQ(NREQ), .ALU_WAIT(WAIT)) dut (
        .clk(clk), .rst_n(rst_n), .rq(rq),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_op(alu_op),
        .alu_w(alu_w), .alu_z(alu_z), .alu_n(alu_n),
        .busy(busy), .op_count(op_count)
    );

    // Bench ALU: {n, z, w}
    function automatic logic [17:0] alu_f(logic [15:0] a, logic [15:0] b, logic c, logic [2:0] op);
        logic [15:0] w;
        case (op)
            3'd0: w = a + b + {15'd0, c};
            3'd1: w = a - b - {15'd0, c};
            3'd2: w = a & b;
            3'd3: w = a | b;
            3'd4: w = a ^ b;
            3'd5: w = ~a;
            3'd6: w = {a[14:0], c};
            default: w = {c, a[15:1]};
        endcase
        return {w[15], (w == 16'h0000), w};
    endfunction

    assign {alu_n, alu_z, alu_w} = alu_f(alu_a, alu_b, alu_cin, alu_op);

    // Per-requester drive state, packed onto the interface.
    logic        r_req [NREQ];
    logic [15:0] r_a   [NREQ];
    logic [15:0] r_b   [NREQ];
    logic        r_cin [NREQ];
    logic [2:0]  r_op  [NREQ];

    always_comb begin
        rq.req = '0; rq.req_a = '0; rq.req_b = '0; rq.req_cin = '0; rq.req_op = '0;
        for (int i = 0; i < NREQ; i++) begin
            rq.req[i]          = r_req[i];
            rq.req_a[16*i +: 16] = r_a[i];
            rq.req_b[16*i +: 16] = r_b[i];
            rq.req_cin[i]      = r_cin[i];
            rq.req_op[3*i +: 3] = r_op[i];
        end
    end

    typedef struct {
        int          id;
        logic [15:0] w;
        logic        z;
        logic        n;
    } exp_t;

    exp_t exp_q[$];
    int   ack_log[$];
    int   ack_cyc[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, want, $time);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic [NREQ-1:0] req_smp;
    logic [NREQ-1:0] prev_grant = '0;
    logic [NREQ-1:0] prev_ack = '0;
    int m_ptr = 0;
    int gcnt = 0;
    int done = 0;

    always @(negedge clk) req_smp <= rq.req;

    always @(posedge clk) begin
        int exp_win, id, hit;
        logic [NREQ-1:0] oh;
        #1;
        if (!rst_n) begin
            m_ptr = 0; done = 0; gcnt = 0;
            prev_grant = '0; prev_ack = '0;
        end else begin
            chk("busy_vs_grant", {31'd0, busy}, {31'd0, (rq.grant != '0)});
            if (prev_ack != '0) begin
                chk("ack_one_cycle", 32'(rq.ack), 32'd0);
                chk("grant_release", 32'(rq.grant), 32'd0);
            end
            if (rq.grant != '0 && prev_grant == '0) begin
                exp_win = -1;
                for (int k = 0; k < NREQ; k++)
                    if (exp_win < 0 && req_smp[(m_ptr + k) % NREQ]) exp_win = (m_ptr + k) % NREQ;
                oh = '0;
                if (exp_win >= 0) oh[exp_win] = 1'b1;
                chk("grant_rr", 32'(rq.grant), 32'(oh));
                gcnt = 0;
            end else if (rq.grant != '0) begin
                gcnt++;
            end
            if (rq.ack != '0 && prev_ack == '0) begin
                chk("ack_owner", 32'(rq.ack), 32'(rq.grant));
                chk("latency", gcnt, WAIT);
                id = 0;
                for (int k = NREQ - 1; k >= 0; k--) if (rq.ack[k]) id = k;
                done++;
                ack_log.push_back(id);
                ack_cyc.push_back(cyc);
                m_ptr = (id + 1) % NREQ;
                hit = -1;
                foreach (exp_q[j]) if (hit < 0 && exp_q[j].id == id) hit = j;
                if (hit < 0) begin
                    chk("unexpected_ack", 32'(id), 32'hFFFF_FFFF);
                end else begin
                    chk("res_w", 32'(rq.res_w), 32'(exp_q[hit].w));
                    chk("res_z", 32'(rq.res_z), 32'(exp_q[hit].z));
                    chk("res_n", 32'(rq.res_n), 32'(exp_q[hit].n));
                    exp_q.delete(hit);
                end
                chk("op_count", 32'(op_count), STATS ? ((done > 65535) ? 32'd65535 : 32'(done)) : 32'd0);
            end
            prev_grant = rq.grant;
            prev_ack = rq.ack;
        end
    end

    // ---------------- stimulus ----------------
    // Issue one request, push its expected result, hold until ack, drop req in the ack cycle.
    // Operands are scrambled once the grant is seen: the scheduler must ignore that.
    task automatic do_op(input int i, input logic [15:0] a, input logic [15:0] b,
                         input logic c, input logic [2:0] op);
        exp_t e;
        logic [17:0] r;
        bit seen = 0, got = 0;
        r = alu_f(a, b, c, op);
        e.id = i; e.w = r[15:0]; e.z = r[16]; e.n = r[17];
        exp_q.push_back(e);
        r_a[i] = a; r_b[i] = b; r_cin[i] = c; r_op[i] = op;
        r_req[i] = 1'b1;
        for (int t = 0; t < 200 && !got; t++) begin
            @(posedge clk); #2;
            if (rq.grant[i] && !seen) begin
                seen = 1;
                r_a[i] = 16'($urandom); r_b[i] = 16'($urandom);
                r_cin[i] = 1'($urandom); r_op[i] = 3'($urandom);
            end
            if (rq.ack[i]) got = 1;
        end
        if (!got) chk("ack_timeout", 32'(i), 32'hFFFF_FFFF);
        r_req[i] = 1'b0;
    endtask

    task automatic rand_agent(input int i, input int n);
        logic [15:0] a, b;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 4)) begin @(posedge clk); #2; end
            a = ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom);
            b = ($urandom_range(0, 5) == 0) ? a : 16'($urandom);
            do_op(i, a, b, 1'($urandom), 3'($urandom));
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            r_req[i] = 1'b0; r_a[i] = '0; r_b[i] = '0; r_cin[i] = 1'b0; r_op[i] = '0;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_grant", 32'(rq.grant), 0);
        chk("rst_ack", 32'(rq.ack), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_alu_a", 32'(alu_a), 0);
        chk("rst_alu_b", 32'(alu_b), 0);
        chk("rst_alu_op", 32'(alu_op), 0);
        chk("rst_alu_cin", 32'(alu_cin), 0);
        chk("rst_res", 32'({rq.res_n, rq.res_z, rq.res_w}), 0);
        chk("rst_op_count", 32'(op_count), 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        idle_cycles(2);

        // Single request and result hold.
        do_op(2, 16'h0005, 16'h0003, 1'b0, 3'd0);
        chk("single_res_w", 32'(rq.res_w), 32'h0008);
        chk("single_flags", 32'({rq.res_z, rq.res_n}), 0);
        idle_cycles(3);
        chk("res_hold", 32'(rq.res_w), 32'h0008);

        // Flags.
        do_op(0, 16'h0000, 16'h0000, 1'b0, 3'd0);
        chk("zero_flag", 32'(rq.res_z), 1);
        do_op(1, 16'h8000, 16'h0001, 1'b0, 3'd0);
        chk("neg_flag", 32'(rq.res_n), 1);
        chk("neg_res_w", 32'(rq.res_w), 32'h8001);
        idle_cycles(2);

        // Fairness: req[1] held across three ops, req[3] arrives during the first.
        ack_log.delete();
        fork
            begin
                do_op(1, 16'd100, 16'd1, 1'b0, 3'd1);
                do_op(1, 16'd200, 16'd2, 1'b0, 3'd1);
                do_op(1, 16'd300, 16'd3, 1'b0, 3'd1);
            end
            begin
                for (int t = 0; t < 50 && !rq.grant[1]; t++) begin @(posedge clk); #2; end
                do_op(3, 16'h00F0, 16'h0F00, 1'b0, 3'd3);
            end
        join
        chk("fair_len", ack_log.size(), 4);
        if (ack_log.size() == 4) begin
            chk("fair_0", ack_log[0], 1);
            chk("fair_1", ack_log[1], 3);
            chk("fair_2", ack_log[2], 1);
            chk("fair_3", ack_log[3], 1);
        end
        idle_cycles(2);

        // Reset in the middle of an operation (no expectation queued: any ack is an error).
        r_a[2] = 16'h1234; r_b[2] = 16'h0001; r_cin[2] = 1'b0; r_op[2] = 3'd0;
        r_req[2] = 1'b1;
        for (int t = 0; t < 20 && !busy; t++) begin @(posedge clk); #2; end
        @(posedge clk); #3;
        rst_n = 1'b0;
        r_req[2] = 1'b0;
        #1;
        chk("midrst_grant", 32'(rq.grant), 0);
        chk("midrst_ack", 32'(rq.ack), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_res_w", 32'(rq.res_w), 0);
        chk("midrst_alu_a", 32'(alu_a), 0);
        chk("midrst_op_count", 32'(op_count), 0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        idle_cycles(2);

        // All four requesting from reset: strict rotation at the minimum issue interval.
        ack_log.delete();
        ack_cyc.delete();
        fork
            begin do_op(0, 16'h0011, 16'h0001, 1'b0, 3'd0); do_op(0, 16'h0022, 16'h0003, 1'b1, 3'd1); end
            begin do_op(1, 16'h0F0F, 16'h00FF, 1'b0, 3'd2); do_op(1, 16'h1234, 16'h4321, 1'b0, 3'd4); end
            begin do_op(2, 16'hA5A5, 16'h0000, 1'b0, 3'd5); do_op(2, 16'h8001, 16'h0000, 1'b1, 3'd6); end
            begin do_op(3, 16'h0003, 16'h0000, 1'b1, 3'd7); do_op(3, 16'h7FFF, 16'h0001, 1'b0, 3'd0); end
        join
        chk("rot_len", ack_log.size(), 8);
        if (ack_log.size() == 8) begin
            for (int k = 0; k < 8; k++) chk("rot_order", ack_log[k], k % NREQ);
            for (int k = 1; k < 8; k++) chk("rot_interval", ack_cyc[k] - ack_cyc[k-1], WAIT + 2);
        end

        // Two more to reach ten completions since reset.
        do_op(2, 16'h0001, 16'h0001, 1'b0, 3'd0);
        do_op(3, 16'h0002, 16'h0002, 1'b0, 3'd0);
        chk("op_count_10", 32'(op_count), STATS ? 32'd10 : 32'd0);
        idle_cycles(2);

        // Randomized contention.
        fork
            rand_agent(0, 12);
            rand_agent(1, 12);
            rand_agent(2, 12);
            rand_agent(3, 12);
        join
        idle_cycles(5);
        chk("sb_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
